// File: rtl/mips_mem_initiator.sv
// mips_mem_initiator: turns one CPU load/store into a single aligned word bus access
// with byte enables, then returns extended load data or store completion.
module mips_mem_initiator #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic [31:0] readdata,
    input  logic        waitrequest
);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT_DATA = 2'd2, RESP = 2'd3;
    logic [1:0]  state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        req_bad, is_store;
    logic [1:0]  size, lane;
    logic [3:0]  be;
    logic [31:0] wd_lane, rd_shift, rd_ext;

    assign is_store = op_q[3];
    assign size     = op_q[1:0];
    assign lane     = addr_q[1:0];
    assign req_bad  = !(req_op inside {4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd11})
                   || (req_op[1:0] == 2'd1 && req_addr[0])
                   || (req_op[1:0] == 2'd3 && req_addr[1:0] != 2'd0);

    assign be       = size == 2'd0 ? 4'b0001 << lane
                    : size == 2'd1 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wd_lane  = size == 2'd0 ? {24'd0, wdata_q[7:0]} << {lane, 3'b000}
                    : size == 2'd1 ? (lane[1] ? {wdata_q[15:0], 16'd0} : {16'd0, wdata_q[15:0]})
                    : wdata_q;
    // op_q[2] marks the unsigned load variants
    assign rd_shift = readdata >> {lane, 3'b000};
    assign rd_ext   = size == 2'd0 ? {{24{rd_shift[7] & ~op_q[2]}}, rd_shift[7:0]}
                    : size == 2'd1 ? {{16{rd_shift[15] & ~op_q[2]}}, rd_shift[15:0]}
                    : readdata;

    assign req_ready  = state_q == IDLE;
    assign resp_valid = state_q == RESP;
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign resp_err   = resp_valid & err_q;
    assign address    = state_q == ISSUE ? {addr_q[31:2], 2'b00} : '0;
    assign byteenable = state_q == ISSUE ? be : '0;
    assign read       = state_q == ISSUE && !is_store;
    assign write      = state_q == ISSUE && is_store;
    assign writedata  = write ? wd_lane : '0;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE && req_valid) begin
            op_d    = req_op;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            err_d   = req_bad;
            rdata_d = '0;
            state_d = req_bad ? RESP : ISSUE;
        end
        if (state_q == ISSUE && !waitrequest) begin
            state_d = is_store ? RESP : WAIT_DATA;
            cnt_d   = 3'(READ_LATENCY);
        end
        // readdata is valid on the edge where the countdown reaches zero
        if (state_q == WAIT_DATA) begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
                rdata_d = rd_ext;
                state_d = RESP;
            end
        end
        if (state_q == RESP) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_mips_mem_initiator.sv
// tb_mips_mem_initiator: two initiators (read latency 1 and 3) share the request stream;
// each has its own bus memory and a scoreboard fed by a byte-level reference model.
module tb_mips_mem_initiator;
    typedef struct {
        logic        err;
        logic [31:0] rd;
        logic        is_load;
        int          nw;
        int          t0;
        logic [31:0] ba;
        logic [3:0]  be;
        logic [31:0] wd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [3:0]  req_op = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready[2], resp_valid[2], resp_err[2], write[2], read[2], waitrequest[2];
    logic [31:0] resp_rdata[2], address[2], writedata[2], readdata[2];
    logic [3:0]  byteenable[2];
    logic [31:0] rmem[256];
    logic [31:0] bmem[2][256];
    exp_t        exp_q[2][$];
    int          rcnt[2], wc[2], pend[2];
    logic [31:0] pword[2], ha[2], hwd[2];
    logic [5:0]  hc[2];
    logic        hw[2];
    int          nwait = 0, cyc = 0, checks = 0, errors = 0;
    logic [3:0]  legal[8] = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd11};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    // Byte-by-byte view of memory: a sz-byte access starting at byte a[1:0] of word a[9:2]
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] wd, input int nw);
        exp_t e;
        int sz, ln;
        sz = op[1:0] == 2'd0 ? 1 : op[1:0] == 2'd1 ? 2 : 4;
        ln = int'(a[1:0]);
        e.err = !(op inside {4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd11}) || (ln % sz != 0);
        e.rd = '0;
        e.is_load = !op[3];
        e.nw = nw;
        e.t0 = 0;
        e.ba = {a[31:2], 2'b00};
        e.be = '0;
        e.wd = '0;
        if (e.err) return e;
        for (int k = 0; k < sz; k++) begin
            e.be[ln + k] = 1'b1;
            e.wd[8*(ln+k) +: 8] = wd[8*k +: 8];
            if (op[3]) rmem[a[9:2]][8*(ln+k) +: 8] = wd[8*k +: 8];
            else e.rd[8*k +: 8] = rmem[a[9:2]][8*(ln+k) +: 8];
        end
        if (!op[3] && !op[2] && sz < 4 && e.rd[8*sz-1])
            e.rd = e.rd | ~((32'd1 << (8*sz)) - 32'd1);
        return e;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = g == 0 ? 1 : 3;
        mips_mem_initiator #(.READ_LATENCY(LAT)) dut (
            .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[g]),
            .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
            .resp_valid(resp_valid[g]), .resp_rdata(resp_rdata[g]), .resp_err(resp_err[g]),
            .address(address[g]), .write(write[g]), .read(read[g]),
            .byteenable(byteenable[g]), .writedata(writedata[g]),
            .readdata(readdata[g]), .waitrequest(waitrequest[g])
        );

        // bus memory: stalls, registered read data, byte-enabled writes, command checks
        always @(negedge clk) begin : slave
            logic cmd;
            logic [31:0] m;
            if (pend[g] > 0) begin
                pend[g]--;
                readdata[g] = pend[g] == 0 ? pword[g] : $urandom;
            end else readdata[g] = $urandom;
            cmd = read[g] || write[g];
            if (cmd) chk($sformatf("%0d:rw_exclusive", g), 32'(read[g] & write[g]), 32'd0);
            if (hw[g]) begin
                chk($sformatf("%0d:hold_addr", g), address[g], ha[g]);
                chk($sformatf("%0d:hold_ctl", g), 32'({byteenable[g], read[g], write[g]}), 32'(hc[g]));
                chk($sformatf("%0d:hold_wdata", g), writedata[g], hwd[g]);
            end
            if (cmd && wc[g] < nwait) begin
                waitrequest[g] = 1'b1;
                wc[g]++;
            end else waitrequest[g] = !cmd && ($urandom_range(0, 1) == 1);
            if (cmd && !waitrequest[g]) begin
                if (exp_q[g].size() == 0 || exp_q[g][0].err)
                    chk($sformatf("%0d:unexpected_bus_cmd", g), address[g], 32'hFFFF_FFFF);
                else begin
                    m = '0;
                    for (int k = 0; k < 4; k++) if (exp_q[g][0].be[k]) m[8*k +: 8] = 8'hFF;
                    chk($sformatf("%0d:bus_addr", g), address[g], exp_q[g][0].ba);
                    chk($sformatf("%0d:bus_be", g), 32'(byteenable[g]), 32'(exp_q[g][0].be));
                    chk($sformatf("%0d:bus_read", g), 32'(read[g]), 32'(exp_q[g][0].is_load));
                    if (write[g]) begin
                        chk($sformatf("%0d:bus_wdata", g), writedata[g] & m, exp_q[g][0].wd);
                        for (int k = 0; k < 4; k++)
                            if (byteenable[g][k]) bmem[g][address[g][9:2]][8*k +: 8] = writedata[g][8*k +: 8];
                    end else begin
                        pend[g] = LAT;
                        pword[g] = bmem[g][address[g][9:2]];
                    end
                end
            end
            hw[g] = waitrequest[g] && cmd;
            ha[g] = address[g];
            hc[g] = {byteenable[g], read[g], write[g]};
            hwd[g] = writedata[g];
        end

        always @(negedge clk) begin : monitor
            exp_t e;
            if (resp_valid[g]) begin
                if (exp_q[g].size() == 0)
                    chk($sformatf("%0d:spurious_resp", g), resp_rdata[g], 32'hFFFF_FFFF);
                else begin
                    e = exp_q[g].pop_front();
                    chk($sformatf("%0d:resp_err", g), 32'(resp_err[g]), 32'(e.err));
                    chk($sformatf("%0d:resp_rdata", g), resp_rdata[g], e.rd);
                    chk($sformatf("%0d:latency", g), 32'(cyc - e.t0),
                        32'(e.err ? 1 : e.is_load ? 2 + e.nw + LAT : 2 + e.nw));
                end
                rcnt[g]++;
            end
        end
    end

    task automatic idle_check(input string nm);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("%0d:%s_ready", g, nm), 32'(req_ready[g]), 32'd1);
            chk($sformatf("%0d:%s_bus", g, nm), 32'({read[g], write[g], byteenable[g]}), 32'd0);
            chk($sformatf("%0d:%s_addr", g, nm), address[g] | writedata[g], 32'd0);
            chk($sformatf("%0d:%s_resp", g, nm), 32'({resp_valid[g], resp_err[g]}) | resp_rdata[g], 32'd0);
        end
    endtask

    task automatic do_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd, input int nw);
        exp_t e;
        int t0, t1;
        e = model(op, a, wd, nw);
        @(negedge clk);
        for (int g = 0; g < 2; g++) chk($sformatf("%0d:req_ready", g), 32'(req_ready[g]), 32'd1);
        req_valid = 1'b1;
        req_op = op;
        req_addr = a;
        req_wdata = wd;
        nwait = nw;
        wc[0] = 0;
        wc[1] = 0;
        e.t0 = cyc;
        exp_q[0].push_back(e);
        exp_q[1].push_back(e);
        t0 = rcnt[0] + 1;
        t1 = rcnt[1] + 1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op = 4'($urandom);
        req_addr = $urandom;
        req_wdata = $urandom;
        for (int i = 0; i < 60 && !(rcnt[0] == t0 && rcnt[1] == t1); i++) @(negedge clk);
        if (!(rcnt[0] == t0 && rcnt[1] == t1)) chk("resp_timeout", 32'(rcnt[0] + rcnt[1]), 32'(t0 + t1));
    endtask

    initial begin
        exp_t e;
        logic [3:0] op;
        logic [31:0] a;
        for (int g = 0; g < 2; g++) begin
            waitrequest[g] = 1'b0;
            readdata[g] = '0;
            rcnt[g] = 0;
            wc[g] = 0;
            pend[g] = 0;
            hw[g] = 1'b0;
        end
        for (int i = 0; i < 256; i++) rmem[i] = $urandom;
        rmem[0] = 32'h8899AABB;
        for (int i = 0; i < 256; i++) begin
            bmem[0][i] = rmem[i];
            bmem[1][i] = rmem[i];
        end
        repeat (2) @(negedge clk);
        idle_check("reset");
        reset = 1'b0;
        do_req(4'd0, 32'h001, 32'h0, 0);
        do_req(4'd5, 32'h002, 32'h0, 0);
        do_req(4'd1, 32'h002, 32'h0, 0);
        do_req(4'd3, 32'h000, 32'h0, 1);
        do_req(4'd9, 32'h006, 32'h1234ABCD, 0);
        do_req(4'd3, 32'h004, 32'h0, 0);
        do_req(4'd3, 32'h102, 32'h0, 0);
        do_req(4'd2, 32'h010, 32'h0, 0);
        do_req(4'd8, 32'h00B, 32'h000000E7, 2);
        do_req(4'd4, 32'h00B, 32'h0, 0);
        do_req(4'd11, 32'hBFC00010, 32'hDEADBEEF, 3);
        do_req(4'd3, 32'hBFC00010, 32'h0, 3);
        // reset while both initiators sit in WAIT_DATA of a word load
        e = model(4'd3, 32'h004, 32'h0, 0);
        @(negedge clk);
        req_valid = 1'b1;
        req_op = 4'd3;
        req_addr = 32'h004;
        nwait = 0;
        wc[0] = 0;
        wc[1] = 0;
        e.t0 = cyc;
        exp_q[0].push_back(e);
        exp_q[1].push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        idle_check("abort");
        reset = 1'b0;
        for (int g = 0; g < 2; g++) begin
            exp_q[g].delete();
            pend[g] = 0;
            hw[g] = 1'b0;
        end
        repeat (5) @(negedge clk);
        for (int i = 0; i < 250; i++) begin
            op = $urandom_range(0, 3) == 0 ? 4'($urandom_range(0, 15)) : legal[$urandom_range(0, 7)];
            a = $urandom_range(0, 7) == 0 ? $urandom : 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) a = a & ~32'(op[1:0]);
            do_req(op, a, $urandom, $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 4)) : 0);
        end
        repeat (4) @(negedge clk);
        for (int g = 0; g < 2; g++) chk($sformatf("%0d:leftover", g), 32'(exp_q[g].size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
